// File: rtl/obtc_pkg.sv
// Constants, types and the beat-slice helper shared by the 64/256-bit collector and serialiser.
package obtc_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEATS  = LINE_W / WORD_W;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

  // Beat 0 is the most significant slice, matching the collector's packing order.
  function automatic word_t get_beat(input line_t line, input beat_t beat);
    return word_t'(line >> (WORD_W * (BEATS - 1 - int'(beat))));
  endfunction

endpackage

// File: rtl/fifo_256to64_if.sv
// Write strobe, output stream and status signals of the 256-to-64 FIFO.
interface fifo_256to64_if #(
  parameter int unsigned DEPTH = 4
) ();
  import obtc_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             we_in;
  line_t            din;
  logic             clr_ovf;
  logic             dout_ready;
  logic             dout_valid;
  word_t            dout;
  logic             dout_last;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] count;

  modport master (
    output we_in, din, clr_ovf, dout_ready,
    input  dout_valid, dout, dout_last, full, overflow, count
  );

  modport slave (
    input  we_in, din, clr_ovf, dout_ready,
    output dout_valid, dout, dout_last, full, overflow, count
  );

endinterface

// File: rtl/fifo_256to64.sv
// Ring buffer of 256-bit words re-serialised MSB-first as a 64-bit valid/ready stream,
// with a sticky flag for writes dropped while full.
module fifo_256to64 #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_256to64_if.slave        bus
);
  import obtc_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  line_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  beat_t            beat_q, beat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic valid, xfer, pop, accept, drop;

  assign valid  = (count_q != '0);
  assign xfer   = valid && bus.dout_ready;
  assign pop    = xfer && (beat_q == LAST_BEAT);
  // A last-beat pop frees its slot in the same cycle, so a full FIFO can still accept.
  assign accept = bus.we_in && ((count_q < CNT_W'(DEPTH)) || pop);
  assign drop   = bus.we_in && !accept;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (pop) begin
      beat_d   = '0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (xfer) begin
      beat_d = beat_q + beat_t'(1);
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop)             overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout_valid = valid;
  assign bus.dout       = valid ? get_beat(mem_q[rd_ptr_q], beat_q) : '0;
  assign bus.dout_last  = valid && (beat_q == LAST_BEAT);
  assign bus.full       = (count_q == CNT_W'(DEPTH));
  assign bus.overflow   = overflow_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_fifo_256to64.sv
// Self-checking bench: expected beats go to a scoreboard queue when words are written and are
// compared against every accepted output beat.
module tb_fifo_256to64;
  import obtc_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;

  fifo_256to64_if #(.DEPTH(DEPTH)) bus ();

  fifo_256to64 #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q [$];  // {last, beat}

  localparam line_t W_SINGLE =
    256'h0123456789ABCDEF_1111111111111111_2222222222222222_3333333333333333;

  // Inputs change only at posedge+1, so a negedge sample sees what the next edge will see.
  always @(negedge clk) begin
    if (rst && bus.dout_valid && bus.dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got beat %h last %b, required no beat", bus.dout,
                 bus.dout_last);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({bus.dout_last, bus.dout} !== e) begin
          errors++;
          $display("FAIL sb_beat: got last=%b %h, required last=%b %h", bus.dout_last, bus.dout,
                   e[64], e[63:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input line_t w);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({(b == 3), w[255-64*b -: 64]});
    end
  endtask

  task automatic write_word(input line_t w, input bit keep);
    bus.we_in = 1'b1;
    bus.din   = w;
    if (keep) push_word(w);
    tick();
    bus.we_in = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic test_reset();
    line_t wb;
    rst = 1'b0;
    #2;
    checks++;
    if ({bus.dout_valid, bus.dout_last, bus.full, bus.overflow} !== 4'b0 || bus.dout !== '0 ||
        bus.count !== '0) begin
      errors++;
      $display("FAIL reset_por: got valid=%b last=%b full=%b ovf=%b count=%0d dout=%h, required 0",
               bus.dout_valid, bus.dout_last, bus.full, bus.overflow, bus.count, bus.dout);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // Mid-word reset: beat 0 taken, beat 1 showing.
    bus.dout_ready = 1'b1;
    write_word(rand_line(), 1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.dout_valid, bus.dout_last, bus.full, bus.overflow} !== 4'b0 || bus.dout !== '0 ||
        bus.count !== '0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b last=%b full=%b ovf=%b count=%0d dout=%h, required 0",
               bus.dout_valid, bus.dout_last, bus.full, bus.overflow, bus.count, bus.dout);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (bus.count !== '0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got count=%0d valid=%b, required 0 0", bus.count,
               bus.dout_valid);
    end
    wb = rand_line();
    write_word(wb, 1'b1);
    checks++;
    if (bus.dout !== wb[255:192] || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart: got %h valid=%b, required %h valid=1", bus.dout,
               bus.dout_valid, wb[255:192]);
    end
    drain("reset");
  endtask

  task automatic test_single();
    bus.dout_ready = 1'b1;
    write_word(W_SINGLE, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 64'h0123456789ABCDEF || bus.dout_last !== 1'b0)
    begin
      errors++;
      $display("FAIL single_first: got valid=%b %h last=%b, required 1 0123456789abcdef 0",
               bus.dout_valid, bus.dout, bus.dout_last);
    end
    drain("single");
    checks++;
    if (bus.count !== '0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: got count=%0d valid=%b, required 0 0", bus.count,
               bus.dout_valid);
    end
  endtask

  task automatic test_stall();
    bus.dout_ready = 1'b1;
    write_word(W_SINGLE, 1'b1);
    tick();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.dout !== 64'h1111111111111111 || bus.dout_last !== 1'b0 ||
          bus.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got %h last=%b valid=%b, required 1111111111111111 0 1",
                 i, bus.dout, bus.dout_last, bus.dout_valid);
      end
    end
    drain("stall");
  endtask

  task automatic test_fill_overflow();
    line_t w [5];
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = rand_line();
      write_word(w[i], i < 4);
      if (i == 3) begin
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill_full: got full=%b count=%0d ovf=%b, required 1 4 0", bus.full,
                   bus.count, bus.overflow);
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop: got ovf=%b count=%0d full=%b, required 1 4 1", bus.overflow,
               bus.count, bus.full);
    end
    drain("fill");
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== '0) begin
      errors++;
      $display("FAIL fill_sticky: got ovf=%b count=%0d, required 1 0", bus.overflow, bus.count);
    end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_clr: got ovf=%b, required 0", bus.overflow);
    end
  endtask

  task automatic test_simul_pop();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(rand_line(), 1'b1);
    bus.dout_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.dout_last !== 1'b1 || bus.count !== 3'd4) begin
      errors++;
      $display("FAIL simul_setup: got last=%b count=%0d, required 1 4", bus.dout_last, bus.count);
    end
    write_word(rand_line(), 1'b1);
    checks++;
    if (bus.overflow !== 1'b0 || bus.count !== 3'd4) begin
      errors++;
      $display("FAIL simul_pop: got ovf=%b count=%0d, required 0 4", bus.overflow, bus.count);
    end
    drain("simul");
  endtask

  task automatic test_wrap();
    int written = 0;
    int max_cnt = 0;
    for (int cyc = 0; cyc < 2000 && (written < 10 || exp_q.size() != 0); cyc++) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      if (written < 10 && ((exp_q.size() + 3) / 4) < DEPTH) begin
        bus.we_in = 1'b1;
        bus.din   = rand_line();
        push_word(bus.din);
        written++;
      end
      tick();
      bus.we_in = 1'b0;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      checks++;
      if (int'(bus.count) != (exp_q.size() + 3) / 4) begin
        errors++;
        $display("FAIL wrap_count: got %0d, required %0d", bus.count, (exp_q.size() + 3) / 4);
      end
    end
    checks++;
    if (written != 10 || exp_q.size() != 0 || max_cnt > 4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: got written=%0d pending=%0d max=%0d ovf=%b, required 10 0 <=4 0",
               written, exp_q.size(), max_cnt, bus.overflow);
    end
  endtask

  initial begin
    bus.we_in      = 1'b0;
    bus.din        = '0;
    bus.clr_ovf    = 1'b0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_fill_overflow();
    test_simul_pop();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_256to64.md
Name: fifo_256to64

Overview:
- Downstream consumer of the 64-to-256 collector: buffers the 256-bit words produced on its we_out/dout pulse and re-serialises them as 64-bit beats.
- Output side is a valid/ready stream toward the miner result/readback path.
- Decouples the collector, which has no backpressure, from a stalling consumer.
- Flags dropped words sticky instead of silently losing them.

Parameters:
- DEPTH, 4, number of 256-bit entries; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- we_in  input  1  single-cycle write strobe from the collector's we_out.
- din  input  256  word to buffer; sampled when we_in=1.
- clr_ovf  input  1  synchronous clear of overflow.
- dout_ready  input  1  consumer accepts the current beat.
- dout_valid  output  1  a beat is presented on dout.
- dout  output  64  current beat.
- dout_last  output  1  current beat is the 4th (lowest) slice of its word.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; a write was dropped.
- count  output  CNT_W  number of 256-bit entries held, including a partially drained one.

Behaviour:
- Reset (rst=0, async) forces the following; memory contents are don't-care:
  - wr_ptr=0, rd_ptr=0, beat=0, count=0.
  - overflow=0, dout_valid=0, dout_last=0, full=0.
  - dout=0; dout is forced to 0 whenever dout_valid=0.
- Storage: DEPTH x 256 register array; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Beat order per word is MSB first, matching the collector's packing:
  - beat 0 = mem[rd_ptr][255:192]
  - beat 1 = [191:128]
  - beat 2 = [127:64]
  - beat 3 = [63:0]
- Output decode:
  - dout_valid = (count!=0).
  - dout = slice(mem[rd_ptr], beat).
  - dout_last = dout_valid && beat==3.
  - All are derived from registers only; no combinational path from din or we_in to any output.
- Latency: a word written on edge N is visible as beat 0 (dout_valid=1) in the cycle after edge N. Minimum 1 cycle. Draining one word takes 4 accepted beats.
- Handshake:
  - A beat transfers when dout_valid && dout_ready at the edge.
  - While dout_valid=1 and dout_ready=0, dout, dout_last and rd_ptr/beat hold stable.
  - dout_ready has no effect when dout_valid=0.
- Pop: a transfer with beat==3 sets beat to 0 and increments rd_ptr. Any other transfer increments beat.
- Write acceptance: accept = we_in && (count<DEPTH || pop), where pop is a last-beat transfer in the same cycle. On accept, mem[wr_ptr]<=din and wr_ptr increments.
- Count update:
  - accept only: count+1.
  - pop only: count-1.
  - both: count unchanged.
- Drop: we_in && !accept sets overflow=1. Nothing else changes; the stored data is untouched.
- Overflow clearing:
  - clr_ovf=1 clears overflow on the next edge.
  - If clr_ovf coincides with a drop, the drop wins and overflow stays 1.
- Empty plus simultaneous write: the word is stored and appears next cycle. There is no bypass; the word is not presented in the same cycle.
- Overwrite protection: the entry at rd_ptr that is partially drained is never overwritten, because count includes it.
- Reset mid-word: the partially drained word is discarded; after release, output restarts from beat 0 of the next newly written word.
- we_in is never asserted on consecutive cycles by the collector, but the block accepts back-to-back writes anyway. No assumption on din stability outside we_in.

Decomposition:
- Shared package obtc_pkg:
  - WORD_W=64, LINE_W=256, BEATS=LINE_W/WORD_W=4.
  - typedef logic [WORD_W-1:0] word_t.
  - typedef logic [LINE_W-1:0] line_t.
  - The collector uses the same constants.
- Slice selection is a function in obtc_pkg, get_beat(line_t, beat): beat 0 maps to the top slice.
- No sub-module; the ring buffer and the serialiser share occupancy control, so keeping them together avoids a duplicated counter.

Test Plan:
- Reset: assert rst=0 mid-traffic -> all outputs 0 immediately (async); after release, count=0 and dout_valid=0.
- Single word: write din=256'h0123456789ABCDEF_1111111111111111_2222222222222222_3333333333333333 with dout_ready=1 -> next cycle onward, 4 consecutive beats 0123456789ABCDEF, 1111..., 2222..., 3333..., dout_last only on the 4th beat, then count=0.
- Stall: same word, dout_ready low for 5 cycles after beat 1 -> dout holds 64'h1111111111111111 for all 5 cycles, then beats resume in order with none lost or duplicated.
- Fill and overflow: dout_ready=0, 5 writes of words W0..W4 (DEPTH=4) -> full=1 after the 4th write, overflow=1 after the 5th, count=4; draining yields W0..W3 only. Then clr_ovf=1 -> overflow=0.
- Simultaneous write and pop when full: count=4, beat==3 transfer in the same cycle as we_in with W5 -> no overflow, count stays 4, W5 emerges after W3.
- Wrap-around: 10 words with random dout_ready over DEPTH=4 -> output sequence equals input sequence (scoreboard); count never exceeds 4; no overflow when the producer is throttled to at most 1 word per 4 accepted beats.
